serializador_tx: RTL and testbench

SERIALIZADOR_TX -- requirements
Module: serializador_tx

---
 rtl/serializador_tx_pkg.sv | 12 +
 rtl/serializador_tx.sv | 87 ++++++++
 tb/tb_serializador_tx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/serializador_tx_pkg.sv
// Constants and state encoding shared by the phy serializer and receiver lanes.
package serializador_tx_pkg;

  localparam logic [7:0] COMMA_BC  = 8'hBC;
  localparam int         N_BC_INIT = 4;

  typedef enum logic {
    ST_INIT   = 1'b0,
    ST_ACTIVE = 1'b1
  } phy_state_e;

endpackage

// File: rtl/serializador_tx.sv
// One-lane byte serializer: sends a comma preamble, then data bytes MSB first,
// filling every idle byte slot with a comma.
module serializador_tx
  import serializador_tx_pkg::*;
(
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       active_out,
  output logic       data_out
);

  // Handshake: a byte moves at a rising edge where valid_in && ready_out;
  // ready_out is only high for the edge that opens a new byte slot, and the
  // producer holds data_in/valid_in stable until that edge.

  phy_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] bc_cnt_q, bc_cnt_d;
  logic [7:0] byte_q, byte_d;
  logic       data_out_q, data_out_d;

  logic       slot_start;
  logic       accept;
  logic [7:0] next_byte;

  assign slot_start = (bit_cnt_q == 3'd0);
  assign accept     = valid_in && ready_out;
  assign next_byte  = accept ? data_in : COMMA_BC;

  // FSM: state register
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state; the 4th comma load opens the data path
  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && slot_start && bc_cnt_q == 3'(N_BC_INIT - 1)) begin
      state_d = ST_ACTIVE;
    end
  end

  // FSM: outputs, decoded from registers only
  always_comb begin
    active_out = (state_q == ST_ACTIVE);
    ready_out  = slot_start && (state_q == ST_ACTIVE);
  end

  // Datapath next-state
  always_comb begin
    bit_cnt_d  = bit_cnt_q + 3'd1;
    bc_cnt_d   = bc_cnt_q;
    byte_d     = byte_q;
    data_out_d = byte_q[3'd7 - bit_cnt_q];
    if (slot_start) begin
      byte_d     = next_byte;
      data_out_d = next_byte[7];
      if (state_q == ST_INIT) begin
        bc_cnt_d = bc_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      bit_cnt_q  <= 3'd0;
      bc_cnt_q   <= 3'd0;
      byte_q     <= 8'h00;
      data_out_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      bc_cnt_q   <= bc_cnt_d;
      byte_q     <= byte_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_serializador_tx.sv
// Directed bench for serializador_tx: preamble timing, slot contents,
// back-to-back streaming, hold-until-accept and mid-byte reset.
module tb_serializador_tx;
  import serializador_tx_pkg::*;

  logic       clk_32f = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic       active_out;
  logic       data_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[11];
  logic [7:0] exp_q[$];
  logic [7:0] comma;

  serializador_tx dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .active_out (active_out),
    .data_out   (data_out)
  );

  // Clock / watchdog
  always #5 clk_32f = ~clk_32f;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one rising edge; sample 1 time unit later.
  task automatic step();
    @(posedge clk_32f);
    #1;
  endtask

  // 32 edges after reset release: four commas, active at edge 25, ready after edge 32.
  task automatic check_preamble();
    for (int e = 1; e <= 32; e++) begin
      step();
      check($sformatf("pre_bit_e%0d", e), 32'(data_out), 32'(comma[7 - ((e - 1) % 8)]));
      check($sformatf("pre_active_e%0d", e), 32'(active_out), 32'(e >= 25));
      check($sformatf("pre_ready_e%0d", e), 32'(ready_out), 32'((e >= 25) && (e % 8 == 0)));
    end
  endtask

  // One byte slot starting at a boundary; returns the 8 serialized bits.
  task automatic run_slot(input logic [7:0] d, input logic v, output logic [7:0] got);
    check("slot_ready_at_boundary", 32'(ready_out), 32'd1);
    data_in  = d;
    valid_in = v;
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) valid_in = 1'b0;
      got[7 - i] = data_out;
      if (i < 7) check("slot_ready_mid", 32'(ready_out), 32'd0);
    end
  endtask

  initial begin
    logic [7:0]  got;
    logic [7:0]  exp;
    logic [31:0] word;
    logic [15:0] got16;
    logic        rdy;
    logic        accepted;

    comma = COMMA_BC;
    vecs[0]  = '{8'hA5, 1'b1, 8'hA5};
    vecs[1]  = '{8'h00, 1'b0, 8'hBC};
    vecs[2]  = '{8'h3C, 1'b1, 8'h3C};
    vecs[3]  = '{8'hFF, 1'b1, 8'hFF};
    vecs[4]  = '{8'h00, 1'b1, 8'h00};
    vecs[5]  = '{8'hBC, 1'b1, 8'hBC};
    vecs[6]  = '{8'h5A, 1'b0, 8'hBC};
    vecs[7]  = '{8'h12, 1'b1, 8'h12};
    vecs[8]  = '{8'h34, 1'b1, 8'h34};
    vecs[9]  = '{8'h56, 1'b1, 8'h56};
    vecs[10] = '{8'h78, 1'b1, 8'h78};

    // Reset state
    #1 reset = 1'b1;
    #2;
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_ready", 32'(ready_out), 32'd0);
    check("rst_active", 32'(active_out), 32'd0);
    step();
    reset = 1'b0;

    // Idle after reset: 4 preamble commas, then 4 idle comma slots
    check_preamble();
    for (int s = 0; s < 4; s++) begin
      run_slot(8'h00, 1'b0, got);
      check($sformatf("idle_slot%0d", s), 32'(got), 32'(comma));
    end

    // Table-driven slots, consecutive with no gaps
    word = 32'h0;
    foreach (vecs[i]) exp_q.push_back(vecs[i].exp);
    foreach (vecs[i]) begin
      run_slot(vecs[i].data, vecs[i].valid, got);
      exp = exp_q.pop_front();
      check($sformatf("vec%0d", i), 32'(got), 32'(exp));
      if (i >= 7) word = {word[23:0], got};
    end
    check("stream_word", word, 32'h12345678);

    // Valid raised mid-slot and held until accepted at the next boundary
    got16 = 16'h0;
    accepted = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        data_in  = 8'hA5;
        valid_in = 1'b1;
      end
      rdy = ready_out;
      step();
      if (valid_in && rdy) begin
        accepted = 1'b1;
        valid_in = 1'b0;
      end
      got16 = {got16[14:0], data_out};
    end
    check("hold_accepted", 32'(accepted), 32'd1);
    check("hold_stream", 32'(got16), {16'h0, comma, 8'hA5});
    run_slot(8'h00, 1'b0, got);
    check("hold_after_comma", 32'(got), 32'(comma));

    // Reset at bit_cnt=4 of a data byte 0xFF
    data_in  = 8'hFF;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("mid_byte_bit", 32'(data_out), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_data_out", 32'(data_out), 32'd0);
    check("mid_rst_active", 32'(active_out), 32'd0);
    check("mid_rst_ready", 32'(ready_out), 32'd0);
    step();
    check("mid_rst_hold_data_out", 32'(data_out), 32'd0);

    // Release with valid already high: ignored through the preamble
    data_in  = 8'h66;
    valid_in = 1'b1;
    reset    = 1'b0;
    check_preamble();
    run_slot(8'h66, 1'b1, got);
    check("first_active_byte", 32'(got), 32'h66);
    run_slot(8'h00, 1'b0, got);
    check("final_idle", 32'(got), 32'(comma));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
